// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the parameterised serial sequence detector.
package seqdet_pkg;

  localparam logic MODE_MEALY = 1'b0;
  localparam logic MODE_MOORE = 1'b1;
  localparam logic OVL_OFF    = 1'b0;
  localparam logic OVL_ON     = 1'b1;

  // Width of the fill counter that must count 0..pat_w-1.
  function automatic int unsigned fill_w(input int unsigned pat_w);
    int unsigned w;
    w = $clog2(pat_w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating event counter with a sticky saturation flag; clr wins over inc.
module seqdet_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == (CNT_MAX - CNT_W'(1))) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seqdet_param.sv
// Serial sequence detector with reloadable pattern, overlap/Mealy-Moore modes
// and a saturating match counter.
module seqdet_param
  import seqdet_pkg::*;
#(
  parameter int unsigned           PAT_W   = 4,
  parameter logic [PAT_W-1:0]      PAT_RST = PAT_W'(4'b1101),
  parameter int unsigned           CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_vld,
  input  logic             din,
  input  logic             mode_ovl,
  input  logic             mode_moore,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned      HIST_W   = PAT_W - 1;
  localparam int unsigned      FILL_W   = fill_w(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat, pat_nxt;
  logic [HIST_W-1:0] hist, hist_nxt;
  logic [FILL_W-1:0] fill, fill_nxt;
  logic              y_q;
  logic              hit;
  logic [PAT_W-1:0]  window;

  // The incoming bit completes the window; a match needs a full history.
  assign window = {hist, din};
  assign hit    = din_vld & ~pat_load & (fill == FILL_MAX) & (window == pat);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat  <= PAT_RST;
      hist <= '0;
      fill <= '0;
      y_q  <= 1'b0;
    end else begin
      pat  <= pat_nxt;
      hist <= hist_nxt;
      fill <= fill_nxt;
      y_q  <= hit;
    end
  end

  // Pattern reload discards the current bit and restarts history fill.
  always_comb begin
    pat_nxt  = pat;
    hist_nxt = hist;
    fill_nxt = fill;
    if (pat_load) begin
      pat_nxt  = pat_in;
      fill_nxt = '0;
    end else if (din_vld) begin
      hist_nxt = window[HIST_W-1:0];
      if (hit && (mode_ovl == OVL_OFF)) begin
        fill_nxt = '0;
      end else if (fill != FILL_MAX) begin
        fill_nxt = fill + FILL_W'(1);
      end
    end
  end

  assign y = (mode_moore == MODE_MOORE) ? y_q : hit;

  seqdet_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clr   (cnt_clr),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );

endmodule

// File: doc/seqdet_param.md
Name: seqdet_param

Overview:
Parameterised serial sequence detector, successor to the fixed 4-bit Mealy detector.
- Pattern width, pattern value and counter width set by parameters; pattern reloadable at run time.
- Runtime selection of overlapping vs non-overlapping detection and Mealy vs Moore output timing.
- Qualified input stream (din_vld) and a saturating match counter for status readback.
- Sits between a bit-serial front end and the control/status block.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..16.
PAT_RST, 4'b1101, pattern loaded at reset; width PAT_W; MSB is first bit received.
CNT_W, 8, width of match counter.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
din_vld  input  1  din is sampled only in cycles where this is 1.
din  input  1  serial data bit.
mode_ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
mode_moore  input  1  1 = registered (Moore) y, 0 = combinational (Mealy) y.
pat_load  input  1  load pat_in as the new pattern.
pat_in  input  PAT_W  new pattern; MSB first.
cnt_clr  input  1  synchronous clear of match_cnt and cnt_sat.
y  output  1  match pulse.
match_cnt  output  CNT_W  number of matches seen, saturating.
cnt_sat  output  1  sticky flag; 1 once match_cnt has reached all-ones.

Behaviour:
State:
- pat register (PAT_W bits).
- hist shift register (PAT_W-1 bits; newest bit in LSB).
- fill counter (0..PAT_W-1, saturating).
- y_q register, match_cnt, cnt_sat.

Reset (reset=0, async) values:
- pat=PAT_RST, hist=0, fill=0, y_q=0.
- match_cnt=0, cnt_sat=0, so y=0.

Match detection:
- hit = din_vld & ~pat_load & (fill==PAT_W-1) & ({hist,din}==pat).
- Combinational; no match is possible before PAT_W valid bits have been received since the last clear.

History update, on a clock edge with din_vld=1 and pat_load=0:
- No hit: hist <= {hist[PAT_W-3:0],din}; fill <= min(fill+1, PAT_W-1).
- Hit with mode_ovl=1: same shift; fill stays PAT_W-1, so a suffix of the match can start the next one.
- Hit with mode_ovl=0: fill <= 0; hist contents are don't-care.
- With din_vld=0: hist and fill hold; din is ignored.

Output y:
- mode_moore=0: y = hit. Asserted in the same cycle as the completing bit; 0 whenever din_vld=0.
- mode_moore=1: y = y_q.
  - y_q <= hit every edge, so y is a one-cycle pulse on the cycle after the completing bit.
  - Back-to-back hits give consecutive high cycles.
- y_q updates every cycle regardless of mode. A mode change takes effect on y immediately; modes are quasi-static, and behaviour during a toggle is not checked.

pat_load (priority over din):
- pat <= pat_in; fill <= 0; y_q <= 0.
- The din of that cycle is discarded; match_cnt is unaffected.

Counter:
- On a hit: match_cnt <= match_cnt+1 unless it is already all-ones.
- cnt_sat <= 1 when match_cnt becomes all-ones.
- cnt_clr has priority over a same-cycle hit: result is match_cnt=0, cnt_sat=0, and that hit is not counted. y still pulses for it.

Reset mid-stream: all state clears asynchronously, and a partial match is lost.

Decomposition:
- Package seqdet_pkg: localparams MODE_MEALY/MODE_MOORE and OVL_ON/OVL_OFF; a function for the fill-counter width, clog2(PAT_W).
- Sub-module seqdet_sat_cnt: a CNT_W saturating counter with inc, clr (clr priority) and a sticky sat output, reusable by other status blocks.
- Matcher, history and output logic stay in seqdet_param.

Test Plan:
1. Defaults (1101), ovl=1, Mealy; stream 1,1,0,1,1,0,1 with din_vld=1 -> y=1 in the same cycle as bits 4 and 7 only; match_cnt=2.
2. ovl=0, Mealy; same stream -> y=1 at bit 4 only; match_cnt=1.
3. Moore; stream 1,1,0,1,0 -> y=0 during bit 4; y=1 exactly one cycle after; y=0 after that.
4. Mealy; bits 1,1,0,1 with din_vld=0 gaps of 1-3 cycles and din toggling during the gaps -> exactly one y pulse, coincident with the valid final 1; y=0 in all gap cycles.
5. After valid bits 1,1, pulse pat_load with pat_in=4'b0110 (same cycle din=0, vld=1), then 1,1,0,1 -> no hit. Then send 0,1,1,0 -> hit on its final 0; match_cnt=1.
6. CNT_W=2:
   - 4 hits -> match_cnt=3, cnt_sat=1.
   - cnt_clr in the same cycle as the next hit -> match_cnt=0, cnt_sat=0, y still pulses.
   - Drive reset=0 mid-sequence after 1,1,0 -> outputs 0 immediately; releasing reset and sending 1 -> no hit.
